// File: rtl/vga_pkg.sv
// Shared constants for the VGA VRAM path: default timing/geometry, pixel
// format, black colour and the RAM slot encoding used by the arbiter.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int AW       = 19;
  localparam int DW       = 24;

  localparam logic [DW-1:0] COLOR_BLACK = 24'h000000;

  // What the single RAM port does in the next cycle.
  localparam logic [1:0] SLOT_IDLE = 2'd0;
  localparam logic [1:0] SLOT_DISP = 2'd1;
  localparam logic [1:0] SLOT_WR   = 2'd2;
endpackage

// File: rtl/vga_addr_calc.sv
// Combinational scan-coordinate to linear VRAM address.
// Ports:
//   h, v      in  scan column / row
//   addr      out v*H_ACTIVE + h, truncated to AW
//   in_range  out h < H_ACTIVE && v < V_ACTIVE
module vga_addr_calc #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int AW       = 19
) (
  input  logic [9:0]    h,
  input  logic [9:0]    v,
  output logic [AW-1:0] addr,
  output logic          in_range
);
  // Wide enough for 1023*H_ACTIVE + 1023 at any sane line width.
  localparam int FW = (AW > 21) ? AW : 21;
  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  logic [FW-1:0] full;

  generate
    if (H_ACTIVE == 640) begin : g_shift
      // 640 = 512 + 128, so the multiply collapses to two shifts.
      assign full = (FW'(v) << 9) + (FW'(v) << 7) + FW'(h);
    end else begin : g_mul
      assign full = FW'(v) * FW'(H_ACTIVE) + FW'(h);
    end
  endgenerate

  assign addr     = full[AW-1:0];
  assign in_range = (h < H_LIM) && (v < V_LIM);
endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM scheduler. Display fetches win every pix_en slot that
// is visible; the pixel writer gets every other cycle via req/ack.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   pix_en, h_addr,
//   v_addr, valid         scan timing from vga_ctrl
//   vga_data              fetched colour, 3 clocks after pix_en
//   mem_addr/we/wdata     registered RAM port
//   mem_rdata             RAM read data, one cycle after mem_addr
//   wr_req/addr/data      writer request, held until wr_ack
//   wr_ack                pulse while the write is on the RAM port
//   err_overrun           sticky: pix_en in two consecutive cycles
module vga_vram_arbiter #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int AW       = vga_pkg::AW,
  parameter int DW       = vga_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic [9:0]    h_addr,
  input  logic [9:0]    v_addr,
  input  logic          valid,
  output logic [DW-1:0] vga_data,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          err_overrun
);
  import vga_pkg::*;

  logic [AW-1:0] disp_addr;
  logic          in_range;

  vga_addr_calc #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .AW(AW)) u_addr (
    .h        (h_addr),
    .v        (v_addr),
    .addr     (disp_addr),
    .in_range (in_range)
  );

  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] vga_q, vga_d;
  logic          mem_we_q, mem_we_d;
  logic          wr_ack_q, wr_ack_d;
  logic          err_q, err_d;
  logic          pix_q;
  // [0]: address on RAM port, [1]: read data on mem_rdata.
  logic [1:0]    rd_pend_q, rd_pend_d;
  logic [1:0]    slot;
  logic          disp_vis, blank;

  assign disp_vis = pix_en && valid && in_range;
  assign blank    = pix_en && !disp_vis;

  always_comb begin
    slot = SLOT_IDLE;
    if (disp_vis)
      slot = SLOT_DISP;
    else if (wr_req && !wr_ack_q)  // ack cycle masks the still-high request
      slot = SLOT_WR;
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    rd_pend_d   = {rd_pend_q[0], 1'b0};
    case (slot)
      SLOT_DISP: begin
        mem_addr_d   = disp_addr;
        rd_pend_d[0] = 1'b1;
      end
      SLOT_WR: begin
        mem_addr_d  = wr_addr;
        mem_wdata_d = wr_data;
        mem_we_d    = 1'b1;
        wr_ack_d    = 1'b1;
      end
      default: ;
    endcase

    // A blanked pixel is the newer event, so it wins over a late capture.
    vga_d = vga_q;
    if (blank)
      vga_d = COLOR_BLACK;
    else if (rd_pend_q[1])
      vga_d = mem_rdata;

    err_d = err_q | (pix_en & pix_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      vga_q       <= '0;
      rd_pend_q   <= '0;
      err_q       <= 1'b0;
      pix_q       <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      wr_ack_q    <= wr_ack_d;
      vga_q       <= vga_d;
      rd_pend_q   <= rd_pend_d;
      err_q       <= err_d;
      pix_q       <= pix_en;
    end
  end

  assign vga_data    = vga_q;
  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign wr_ack      = wr_ack_q;
  assign err_overrun = err_q;
endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;
  localparam int AW = 19;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_en, valid, wr_req, mem_we, wr_ack, err_overrun;
  logic [9:0]    h_addr, v_addr;
  logic [DW-1:0] vga_data, mem_wdata, mem_rdata, wr_data;
  logic [AW-1:0] mem_addr, wr_addr;

  vga_vram_arbiter dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .h_addr(h_addr), .v_addr(v_addr),
    .valid(valid), .vga_data(vga_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read that returns the address as data.
  always_ff @(posedge clk) mem_rdata <= {5'b0, mem_addr};

  typedef struct {
    logic          pix, val;
    logic [9:0]    h, v;
    logic          req;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wd;
    logic          e_ack;
    logic [DW-1:0] e_vga;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];
  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(logic pix, logic val, int h, int v, logic req, int wa, int wd,
                              int e_addr, logic e_we, int e_wd, logic e_ack, int e_vga);
    vec_t r;
    r.pix = pix; r.val = val; r.h = 10'(h); r.v = 10'(v);
    r.req = req; r.wa = AW'(wa); r.wd = DW'(wd);
    r.e_addr = AW'(e_addr); r.e_we = e_we; r.e_wd = DW'(e_wd);
    r.e_ack = e_ack; r.e_vga = DW'(e_vga);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic vl, input int h, input int v,
                       input logic r, input int wa, input int wd);
    pix_en = p; valid = vl; h_addr = 10'(h); v_addr = 10'(v);
    wr_req = r; wr_addr = AW'(wa); wr_data = DW'(wd);
  endtask

  initial begin
    //                 pix val  h    v  req  wa   wd          addr  we  wd        ack vga
    tbl[0]  = mk(0, 0,   0,   0, 0,   0, 0,          0,      0, 0,        0, 0);
    tbl[1]  = mk(1, 1,   5,   2, 0,   0, 0,          1285,   0, 0,        0, 0);
    tbl[2]  = mk(0, 1,   5,   2, 0,   0, 0,          1285,   0, 0,        0, 0);
    tbl[3]  = mk(1, 1,   6,   2, 0,   0, 0,          1286,   0, 0,        0, 1285);
    tbl[4]  = mk(0, 1,   6,   2, 0,   0, 0,          1286,   0, 0,        0, 1285);
    tbl[5]  = mk(0, 1,   6,   2, 0,   0, 0,          1286,   0, 0,        0, 1286);
    tbl[6]  = mk(1, 0,   7,   2, 0,   0, 0,          1286,   0, 0,        0, 0);
    tbl[7]  = mk(0, 0,   7,   2, 0,   0, 0,          1286,   0, 0,        0, 0);
    tbl[8]  = mk(0, 0,   0,   0, 1, 100, 'hFF0000,   100,    1, 'hFF0000, 1, 0);
    tbl[9]  = mk(0, 0,   0,   0, 1, 100, 'hFF0000,   100,    0, 'hFF0000, 0, 0);
    tbl[10] = mk(0, 0,   0,   0, 0,   0, 0,          100,    0, 'hFF0000, 0, 0);
    tbl[11] = mk(1, 1,   0,   1, 1, 200, 'h00FF00,   640,    0, 'hFF0000, 0, 0);
    tbl[12] = mk(0, 1,   0,   1, 1, 200, 'h00FF00,   200,    1, 'h00FF00, 1, 0);
    tbl[13] = mk(0, 1,   0,   1, 0,   0, 0,          200,    0, 'h00FF00, 0, 640);
    tbl[14] = mk(0, 1,   0,   1, 0,   0, 0,          200,    0, 'h00FF00, 0, 640);
    tbl[15] = mk(1, 1, 640,   0, 0,   0, 0,          200,    0, 'h00FF00, 0, 0);
    tbl[16] = mk(0, 1,   0,   0, 0,   0, 0,          200,    0, 'h00FF00, 0, 0);
    tbl[17] = mk(1, 1, 639, 479, 0,   0, 0,          307199, 0, 'h00FF00, 0, 0);
    tbl[18] = mk(0, 1,   0,   0, 0,   0, 0,          307199, 0, 'h00FF00, 0, 0);
    tbl[19] = mk(0, 1,   0,   0, 0,   0, 0,          307199, 0, 'h00FF00, 0, 307199);
    tbl[20] = mk(1, 1,   0, 480, 0,   0, 0,          307199, 0, 'h00FF00, 0, 0);
    tbl[21] = mk(0, 1,   0,   0, 0,   0, 0,          307199, 0, 'h00FF00, 0, 0);
    tbl[22] = mk(1, 1,   1,   0, 1, 400, 'h0000FF,   1,      0, 'h00FF00, 0, 0);
    tbl[23] = mk(0, 1,   1,   0, 0,   0, 0,          1,      0, 'h00FF00, 0, 0);
    tbl[24] = mk(0, 1,   1,   0, 0,   0, 0,          1,      0, 'h00FF00, 0, 1);

    // Reset state.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("rst_vga",   0, 32'(vga_data), 0);
    chk("rst_addr",  0, 32'(mem_addr), 0);
    chk("rst_we",    0, 32'(mem_we), 0);
    chk("rst_wdata", 0, 32'(mem_wdata), 0);
    chk("rst_ack",   0, 32'(wr_ack), 0);
    chk("rst_err",   0, 32'(err_overrun), 0);
    reset = 1'b0;

    // Table: inputs held for one cycle, registered outputs checked after the edge.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].pix, tbl[i].val, int'(tbl[i].h), int'(tbl[i].v),
            tbl[i].req, int'(tbl[i].wa), int'(tbl[i].wd));
      step();
      chk("addr",  i, 32'(mem_addr),    32'(tbl[i].e_addr));
      chk("we",    i, 32'(mem_we),      32'(tbl[i].e_we));
      chk("wdata", i, 32'(mem_wdata),   32'(tbl[i].e_wd));
      chk("ack",   i, 32'(wr_ack),      32'(tbl[i].e_ack));
      chk("vga",   i, 32'(vga_data),    32'(tbl[i].e_vga));
      chk("err",   i, 32'(err_overrun), 0);
    end

    // Held request: the ack cycle masks it, so it is re-granted every other cycle.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 300, 'h123456);
      step();
      chk("held_ack", i, 32'(wr_ack), (i % 2 == 0) ? 1 : 0);
      chk("held_we",  i, 32'(mem_we), (i % 2 == 0) ? 1 : 0);
    end
    chk("held_addr", 0, 32'(mem_addr), 300);
    chk("held_wd",   0, 32'(mem_wdata), 32'h123456);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("held_end_ack", 0, 32'(wr_ack), 0);

    // Back-to-back pix_en: sticky error, reads still go out.
    drive(1, 1, 2, 0, 0, 0, 0);
    step();
    chk("ovr_err0",  0, 32'(err_overrun), 0);
    chk("ovr_addr0", 0, 32'(mem_addr), 2);
    drive(1, 1, 3, 0, 0, 0, 0);
    step();
    chk("ovr_err1",  0, 32'(err_overrun), 1);
    chk("ovr_addr1", 0, 32'(mem_addr), 3);
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("ovr_sticky", 0, 32'(err_overrun), 1);
    chk("ovr_vga",    0, 32'(vga_data), 3);

    // Reset with a read in flight and a request arriving during reset.
    drive(1, 1, 4, 0, 0, 0, 0);
    step();
    chk("rif_addr", 0, 32'(mem_addr), 4);
    reset = 1'b1;
    drive(0, 1, 0, 0, 1, 500, 'hABCDEF);
    step();
    chk("rif_rst_ack", 0, 32'(wr_ack), 0);
    chk("rif_rst_we",  0, 32'(mem_we), 0);
    chk("rif_rst_err", 0, 32'(err_overrun), 0);
    chk("rif_rst_vga", 0, 32'(vga_data), 0);
    reset = 1'b0;
    step();
    chk("rif_vga1", 0, 32'(vga_data), 0);
    chk("rif_ack",  0, 32'(wr_ack), 1);
    chk("rif_addr2", 0, 32'(mem_addr), 500);
    chk("rif_wd",   0, 32'(mem_wdata), 32'hABCDEF);
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("rif_vga2", 0, 32'(vga_data), 0);
    chk("rif_err",  0, 32'(err_overrun), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
